// File: rtl/param_shift_left_serial_tx_if.sv
// rtl/param_shift_left_serial_tx_if.sv - load handshake and serial output bundle for the serial transmitter
interface param_shift_left_serial_tx_if #(
  parameter int width = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [width-1:0] data_in;
  logic             shift_en;
  logic             data_out;
  logic             out_valid;
  logic             last_bit;

  modport master (
    output load_valid, data_in, shift_en,
    input  load_ready, data_out, out_valid, last_bit
  );

  modport slave (
    input  load_valid, data_in, shift_en,
    output load_ready, data_out, out_valid, last_bit
  );
endinterface

// File: rtl/param_shift_left_serial_tx.sv
// rtl/param_shift_left_serial_tx.sv - parallel-in, MSB-first serial-out transmitter with valid/ready load
module param_shift_left_serial_tx #(
  parameter int   width      = 8,
  parameter logic idle_level = 1'b0
) (
  input logic                          clk,
  input logic                          rst,
  param_shift_left_serial_tx_if.slave  bus
);

  localparam int cw = (width > 2) ? $clog2(width) : 1;
  localparam logic [cw-1:0] cnt_last = cw'(width - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [cw-1:0]    cnt_q, cnt_d;
  logic [width-1:0] shreg_q, shreg_d;
  logic             accept;
  logic             frame_active;
  logic             at_last;

  assign frame_active   = (state_q == SHIFT);
  assign at_last        = frame_active && (cnt_q == cnt_last);

  assign bus.out_valid  = frame_active;
  assign bus.data_out   = frame_active ? shreg_q[width-1] : idle_level;
  assign bus.last_bit   = at_last;
  // shift_en term lets the next word load during the final bit with no gap
  assign bus.load_ready = (state_q == IDLE) || (at_last && bus.shift_en);

  assign accept = bus.load_valid && bus.load_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (accept) begin
      shreg_d = bus.data_in;
      cnt_d   = '0;
      state_d = SHIFT;
    end else if (frame_active && bus.shift_en) begin
      shreg_d = {shreg_q[width-2:0], 1'b0};
      if (cnt_q == cnt_last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

endmodule
